// File: rtl/csrs_rmw_ctrl.sv
// csrs_rmw_ctrl: Zicsr read-modify-write sequencer in front of a CSR bank.
// Define CSRS_RMW_TIMEOUT_EN to bound the wait for CSR_RVALID by TIMEOUT_CYCLES.
module csrs_rmw_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [11:0] REQ_ADDR,
  input  logic [1:0]  REQ_OP,
  input  logic [31:0] REQ_SRC,
  input  logic        REQ_NORD,
  input  logic        REQ_NOWR,
  input  logic        FLUSH,
  output logic        CSR_RDEN,
  output logic [11:0] CSR_RADDR,
  input  logic        CSR_RVALID,
  input  logic [31:0] CSR_RDATA,
  output logic        CSR_WREN,
  output logic [11:0] CSR_WADDR,
  output logic [31:0] CSR_WDATA,
  output logic        RES_VALID,
  input  logic        RES_READY,
  output logic [31:0] RES_DATA,
  output logic        RES_ERR
);
  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, RESP} state_t;
  state_t state, state_nx;
  logic [11:0] addr;
  logic [1:0] op;
  logic [31:0] src, old;
  logic wr, err;
  logic acc, acc_rd, acc_wr, acc_err, got_rd, timed_out;
  assign acc = state == IDLE && REQ_VALID && !FLUSH;
  assign acc_wr = !(REQ_OP[1] && REQ_NOWR);
  assign acc_rd = !(REQ_OP == 2'b01 && REQ_NORD);
  assign acc_err = REQ_OP == 2'b00 || (acc_wr && REQ_ADDR[11:10] == 2'b11);
  assign got_rd = state == WAIT && CSR_RVALID && !FLUSH;
`ifdef CSRS_RMW_TIMEOUT_EN
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);
  logic [7:0] cnt;
  always_ff @(posedge CLK)
    if (!RST || state != WAIT) cnt <= '0;
    else if (!CSR_RVALID) cnt <= cnt + 8'd1;
  assign timed_out = state == WAIT && !CSR_RVALID && !FLUSH && cnt + 8'd1 == TO_LIM;
`else
  assign timed_out = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif
  always_ff @(posedge CLK)
    state <= !RST ? IDLE : state_nx;
  // old stays 0 unless a read returns, so errors and unread RWs report 0
  always_ff @(posedge CLK)
    if (!RST) begin
      addr <= '0;
      op   <= '0;
      src  <= '0;
      wr   <= 1'b0;
      err  <= 1'b0;
      old  <= '0;
    end else if (acc) begin
      addr <= REQ_ADDR;
      op   <= REQ_OP;
      src  <= REQ_SRC;
      wr   <= acc_wr;
      err  <= acc_err;
      old  <= '0;
    end else if (got_rd) old <= CSR_RDATA;
    else if (timed_out) err <= 1'b1;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (acc) state_nx = acc_err ? RESP : acc_rd ? READ : WRITE;
      READ:    state_nx = FLUSH ? IDLE : WAIT;
      WAIT:    state_nx = FLUSH ? IDLE : CSR_RVALID ? (wr ? WRITE : RESP) : timed_out ? RESP : WAIT;
      WRITE:   state_nx = FLUSH ? IDLE : RESP;
      RESP:    if (FLUSH || RES_READY) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    REQ_READY = RST && state == IDLE;
    CSR_RDEN  = RST && state == READ;
    CSR_RADDR = CSR_RDEN ? addr : '0;
    CSR_WREN  = RST && state == WRITE;
    CSR_WADDR = CSR_WREN ? addr : '0;
    CSR_WDATA = !CSR_WREN ? '0 : op == 2'b01 ? src : op == 2'b10 ? (old | src) : (old & ~src);
    RES_VALID = RST && state == RESP;
    RES_DATA  = RES_VALID ? old : '0;
    RES_ERR   = RES_VALID && err;
  end
endmodule

// File: tb/tb_csrs_rmw_ctrl.sv
// tb_csrs_rmw_ctrl: randomized self-checking bench for csrs_rmw_ctrl.
// A 1-cycle-latency bank model answers reads; a transaction-level CSR model predicts results.
module tb_csrs_rmw_ctrl;
  logic        CLK = 1'b0, RST = 1'b0;
  logic        REQ_VALID = 1'b0, REQ_NORD = 1'b0, REQ_NOWR = 1'b0, FLUSH = 1'b0, RES_READY = 1'b0;
  logic [11:0] REQ_ADDR = '0;
  logic [1:0]  REQ_OP = '0;
  logic [31:0] REQ_SRC = '0;
  logic        REQ_READY, CSR_RDEN, CSR_RVALID, CSR_WREN, RES_VALID, RES_ERR;
  logic [11:0] CSR_RADDR, CSR_WADDR;
  logic [31:0] CSR_RDATA, CSR_WDATA, RES_DATA;
  logic        bank_mute = 1'b0, bank_clr = 1'b0, inj_rv = 1'b0, bank_rv = 1'b0;
  logic [31:0] inj_data = '0, bank_rd = '0;
  logic [31:0] bank  [4096];
  logic [31:0] model [4096];
  int checks = 0, errors = 0;

  always #5 CLK = ~CLK;

  csrs_rmw_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_ADDR(REQ_ADDR), .REQ_OP(REQ_OP),
    .REQ_SRC(REQ_SRC), .REQ_NORD(REQ_NORD), .REQ_NOWR(REQ_NOWR), .FLUSH(FLUSH),
    .CSR_RDEN(CSR_RDEN), .CSR_RADDR(CSR_RADDR), .CSR_RVALID(CSR_RVALID), .CSR_RDATA(CSR_RDATA),
    .CSR_WREN(CSR_WREN), .CSR_WADDR(CSR_WADDR), .CSR_WDATA(CSR_WDATA),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_DATA(RES_DATA), .RES_ERR(RES_ERR)
  );

  function automatic logic [31:0] init_val(input int a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  always @(posedge CLK) begin
    bank_rv <= CSR_RDEN;
    bank_rd <= bank[CSR_RADDR];
    if (bank_clr) for (int i = 0; i < 4096; i++) bank[i] <= init_val(i);
    else if (CSR_WREN) bank[CSR_WADDR] <= CSR_WDATA;
  end
  assign CSR_RVALID = (bank_rv && !bank_mute) || inj_rv;
  assign CSR_RDATA  = inj_rv ? inj_data : bank_rd;

  task automatic drive_req(input logic [11:0] a, input logic [1:0] op, input logic [31:0] src,
                           input logic nord, input logic nowr);
    REQ_ADDR = a; REQ_OP = op; REQ_SRC = src; REQ_NORD = nord; REQ_NOWR = nowr; REQ_VALID = 1'b1;
  endtask

  // One full transaction: predict from the CSR rules, then watch the bus cycle by cycle.
  task automatic do_req(input logic [11:0] a, input logic [1:0] op, input logic [31:0] src,
                        input logic nord, input logic nowr, input int hold);
    logic exp_err, exp_rd, exp_wr, done, rerr;
    logic [31:0] old, nv, exp_data, wd, rdat;
    logic [11:0] ra, wa;
    int exp_res_t, rden_t, wren_t, res_t, n_rd, n_wr, hc, w;
    exp_wr   = !(op[1] && nowr);
    exp_err  = (op == 2'b00) || (exp_wr && a[11:10] == 2'b11);
    exp_rd   = !exp_err && !(op == 2'b01 && nord);
    exp_wr   = exp_wr && !exp_err;
    old      = model[a];
    nv       = op == 2'b01 ? src : op == 2'b10 ? (old | src) : (old & ~src);
    exp_data = exp_rd ? old : 32'h0;
    exp_res_t = exp_err ? 1 : 1 + (exp_rd ? 2 : 0) + (exp_wr ? 1 : 0);
    w = 0;
    while (REQ_READY !== 1'b1 && w < 20) begin @(negedge CLK); w++; end
    checks++;
    if (REQ_READY !== 1'b1) begin errors++; $display("FAIL req_ready_wait got=%b want=1", REQ_READY); end
    RES_READY = 1'b0;
    drive_req(a, op, src, nord, nowr);
    rden_t = -1; wren_t = -1; res_t = -1; n_rd = 0; n_wr = 0; hc = 0; done = 1'b0;
    ra = '0; wa = '0; wd = '0; rdat = '0; rerr = 1'b0;
    for (int t = 1; t <= 8 + hold && !done; t++) begin
      @(negedge CLK);
      REQ_VALID = 1'b0;
      if (CSR_RDEN) begin n_rd++; if (rden_t < 0) rden_t = t; ra = CSR_RADDR; end
      if (CSR_WREN) begin n_wr++; if (wren_t < 0) wren_t = t; wa = CSR_WADDR; wd = CSR_WDATA; end
      checks++;
      if ((!CSR_RDEN && CSR_RADDR !== 12'h0) || (!CSR_WREN && (CSR_WADDR !== 12'h0 || CSR_WDATA !== 32'h0))) begin
        errors++; $display("FAIL idle_bus raddr=%h waddr=%h wdata=%h want=0", CSR_RADDR, CSR_WADDR, CSR_WDATA);
      end
      if (RES_VALID) begin
        if (res_t < 0) begin res_t = t; rdat = RES_DATA; rerr = RES_ERR; end
        else begin
          checks++;
          if (RES_DATA !== rdat || RES_ERR !== rerr) begin
            errors++; $display("FAIL res_stable data=%h err=%b want data=%h err=%b", RES_DATA, RES_ERR, rdat, rerr);
          end
        end
        if (hc >= hold) begin RES_READY = 1'b1; done = 1'b1; end else hc++;
      end
    end
    @(negedge CLK);
    RES_READY = 1'b0;
    checks++;
    if (!done) begin errors++; $display("FAIL res_timeout addr=%h op=%b got no response want response", a, op); end
    checks++;
    if (res_t != exp_res_t) begin errors++; $display("FAIL res_latency addr=%h op=%b got=%0d want=%0d", a, op, res_t, exp_res_t); end
    checks++;
    if (rdat !== exp_data || rerr !== exp_err) begin
      errors++; $display("FAIL res_value addr=%h op=%b got data=%h err=%b want data=%h err=%b", a, op, rdat, rerr, exp_data, exp_err);
    end
    checks++;
    if (n_rd != (exp_rd ? 1 : 0) || (exp_rd && (rden_t != 1 || ra !== a))) begin
      errors++; $display("FAIL read_strobe addr=%h got n=%0d t=%0d raddr=%h want n=%0d t=1", a, n_rd, rden_t, ra, exp_rd ? 1 : 0);
    end
    checks++;
    if (n_wr != (exp_wr ? 1 : 0) || (exp_wr && (wren_t != (exp_rd ? 3 : 1) || wa !== a || wd !== nv))) begin
      errors++; $display("FAIL write_strobe addr=%h got n=%0d t=%0d waddr=%h wdata=%h want n=%0d t=%0d wdata=%h",
                         a, n_wr, wren_t, wa, wd, exp_wr ? 1 : 0, exp_rd ? 3 : 1, nv);
    end
    checks++;
    if (REQ_READY !== 1'b1 || RES_VALID !== 1'b0) begin
      errors++; $display("FAIL back_to_idle got ready=%b valid=%b want ready=1 valid=0", REQ_READY, RES_VALID);
    end
    if (exp_wr) model[a] = nv;
  endtask

  task automatic test_reset;
    RST = 1'b0; bank_clr = 1'b1;
    for (int i = 0; i < 4096; i++) model[i] = init_val(i);
    repeat (3) @(negedge CLK);
    checks++;
    if ({REQ_READY, CSR_RDEN, CSR_WREN, RES_VALID, RES_ERR} !== 5'b0 || CSR_RADDR !== 12'h0 ||
        CSR_WADDR !== 12'h0 || CSR_WDATA !== 32'h0 || RES_DATA !== 32'h0) begin
      errors++; $display("FAIL reset_outputs ready=%b rden=%b wren=%b valid=%b err=%b want all 0",
                         REQ_READY, CSR_RDEN, CSR_WREN, RES_VALID, RES_ERR);
    end
    bank_clr = 1'b0; RST = 1'b1;
    #1;
    checks++;
    if (REQ_READY !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b want=1", REQ_READY); end
  endtask

  task automatic test_rw_readback;
    do_req(12'h340, 2'b01, 32'h1234_5678, 1'b0, 1'b0, 0);
    do_req(12'h340, 2'b01, 32'hDEAD_BEEF, 1'b0, 1'b0, 0);
    do_req(12'h341, 2'b01, 32'hCAFE_F00D, 1'b1, 1'b0, 0);
  endtask

  task automatic test_set_clear;
    do_req(12'h300, 2'b01, 32'h0000_00F0, 1'b0, 1'b0, 0);
    do_req(12'h300, 2'b10, 32'h0000_000F, 1'b0, 1'b0, 0);
    do_req(12'h300, 2'b11, 32'h0000_00F0, 1'b0, 1'b0, 0);
    do_req(12'h300, 2'b10, 32'h0000_0000, 1'b0, 1'b1, 0);
    do_req(12'h300, 2'b11, 32'h0000_0000, 1'b1, 1'b1, 0);
  endtask

  task automatic test_read_only;
    do_req(12'hC00, 2'b10, 32'h0000_0005, 1'b0, 1'b1, 0);
    do_req(12'hC00, 2'b10, 32'h0000_0005, 1'b0, 1'b0, 0);
    do_req(12'hF12, 2'b01, 32'h1111_1111, 1'b1, 1'b0, 0);
    do_req(12'h300, 2'b00, 32'h2222_2222, 1'b0, 1'b0, 0);
  endtask

  task automatic test_backpressure;
    do_req(12'h340, 2'b11, 32'h0F0F_0F0F, 1'b0, 1'b0, 5);
    do_req(12'hC01, 2'b00, 32'h0, 1'b0, 1'b0, 3);
  endtask

  task automatic test_flush;
    int nw, nr;
    drive_req(12'h340, 2'b01, $urandom, 1'b0, 1'b0);
    FLUSH = 1'b1;
    @(negedge CLK);
    REQ_VALID = 1'b0; FLUSH = 1'b0;
    checks++;
    if (REQ_READY !== 1'b1 || CSR_RDEN !== 1'b0) begin
      errors++; $display("FAIL flush_idle got ready=%b rden=%b want ready=1 rden=0", REQ_READY, CSR_RDEN);
    end
    bank_mute = 1'b1;
    REQ_VALID = 1'b1;
    @(negedge CLK);
    REQ_VALID = 1'b0;
    checks++;
    if (CSR_RDEN !== 1'b1) begin errors++; $display("FAIL flush_read_strobe got=%b want=1", CSR_RDEN); end
    @(negedge CLK);
    FLUSH = 1'b1;
    @(negedge CLK);
    FLUSH = 1'b0; inj_rv = 1'b1; inj_data = $urandom;
    checks++;
    if (REQ_READY !== 1'b1) begin errors++; $display("FAIL flush_wait_ready got=%b want=1", REQ_READY); end
    nw = 0; nr = 0;
    repeat (6) begin
      @(negedge CLK);
      inj_rv = 1'b0;
      nw += int'(CSR_WREN); nr += int'(RES_VALID);
    end
    checks++;
    if (nw != 0 || nr != 0) begin errors++; $display("FAIL flush_wait_quiet got wren=%0d valid=%0d want 0 0", nw, nr); end
    bank_mute = 1'b0;
  endtask

  task automatic test_stall;
    int nb;
    bank_mute = 1'b1;
    drive_req(12'h340, 2'b01, $urandom, 1'b0, 1'b0);
    @(negedge CLK);
    REQ_VALID = 1'b0;
`ifdef CSRS_RMW_TIMEOUT_EN
    nb = 0;
    for (int t = 0; t < 20 && RES_VALID !== 1'b1; t++) begin @(negedge CLK); nb += int'(CSR_WREN); end
    checks++;
    if (RES_VALID !== 1'b1 || RES_ERR !== 1'b1 || RES_DATA !== 32'h0 || nb != 0) begin
      errors++; $display("FAIL timeout_resp got valid=%b err=%b data=%h wren=%0d want 1 1 0 0", RES_VALID, RES_ERR, RES_DATA, nb);
    end
    RES_READY = 1'b1;
    @(negedge CLK);
    RES_READY = 1'b0;
`else
    nb = 0;
    repeat (100) begin
      @(negedge CLK);
      if (RES_VALID || CSR_WREN || REQ_READY) nb++;
    end
    checks++;
    if (nb != 0) begin errors++; $display("FAIL stall_wait got %0d active cycles want 0", nb); end
    FLUSH = 1'b1;
    @(negedge CLK);
    FLUSH = 1'b0;
`endif
    checks++;
    if (REQ_READY !== 1'b1) begin errors++; $display("FAIL stall_recover got ready=%b want=1", REQ_READY); end
    bank_mute = 1'b0;
  endtask

  task automatic test_reset_mid;
    int nw;
    bank_mute = 1'b1;
    drive_req(12'h340, 2'b01, $urandom, 1'b0, 1'b0);
    @(negedge CLK);
    REQ_VALID = 1'b0;
    @(negedge CLK);
    RST = 1'b0; inj_rv = 1'b1; inj_data = $urandom;
    @(negedge CLK);
    checks++;
    if ({REQ_READY, CSR_RDEN, CSR_WREN, RES_VALID, RES_ERR} !== 5'b0 || CSR_WDATA !== 32'h0 || RES_DATA !== 32'h0) begin
      errors++; $display("FAIL reset_mid_outputs ready=%b rden=%b wren=%b valid=%b want all 0",
                         REQ_READY, CSR_RDEN, CSR_WREN, RES_VALID);
    end
    RST = 1'b1; inj_rv = 1'b0;
    nw = 0;
    repeat (5) begin @(negedge CLK); nw += int'(CSR_WREN); end
    checks++;
    if (nw != 0 || REQ_READY !== 1'b1) begin
      errors++; $display("FAIL reset_mid_no_write got wren=%0d ready=%b want 0 1", nw, REQ_READY);
    end
    bank_mute = 1'b0;
  endtask

  task automatic test_random;
    logic [11:0] a;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: a = 12'h300;
        1: a = 12'h340;
        2: a = 12'hC00;
        default: a = 12'($urandom);
      endcase
      a[1:0] = 2'($urandom);
      do_req(a, 2'($urandom), $urandom, 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    test_reset;
    test_rw_readback;
    test_set_clear;
    test_read_only;
    test_backpressure;
    test_flush;
    test_stall;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
